// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the timing generator and the block renderers.
// Holds the 640x480@60 segment lengths, derived totals and sync windows, the
// colour width, and the counter widths used on the raster bus.
package vga_pkg;

    localparam int CLK_DIV = 4;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int RGB_W = 8;
    localparam int CNT_W = 10;
    localparam int Y_W   = 9;

    function automatic logic [CNT_W-1:0] to_cnt(input int value);
        return CNT_W'(value);
    endfunction

endpackage

// File: rtl/vga_if.sv
// Raster bus between the timing generator (master) and the renderers (slave).
// Master drives pix_en, x_counter, y_counter and the registered pin outputs
// rgb_out/hsync/vsync/frame_start; the slave returns the combined colour rgb_in.
interface vga_if import vga_pkg::*; #(
    parameter int COLOR_W = RGB_W
);
    logic               pix_en;
    logic [CNT_W-1:0]   x_counter;
    logic [Y_W-1:0]     y_counter;
    logic [COLOR_W-1:0] rgb_in;
    logic [COLOR_W-1:0] rgb_out;
    logic               hsync;
    logic               vsync;
    logic               frame_start;

    modport master (
        output pix_en, x_counter, y_counter, rgb_out, hsync, vsync, frame_start,
        input  rgb_in
    );

    modport slave (
        input  pix_en, x_counter, y_counter, rgb_out, hsync, vsync, frame_start,
        output rgb_in
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..total-1 on enabled clocks.
// Ports: clk, rst_n (sync, active-low), enable, total (axis length),
//        count (current position), wrap (enabled step out of total-1).
module vga_axis_counter import vga_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] total,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);
    logic at_last;

    assign at_last = (count == total - CNT_W'(1));
    assign wrap    = enable && at_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable) begin
            count <= at_last ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: divides clk into a one-clk pixel enable, runs the
// h/v counters, and registers colour (blanked outside the active area),
// hsync, vsync and the frame-start pulse to the pins.
// Ports: clk, rst_n (sync, active-low), bus (vga_if master: pix_en,
//        x_counter, y_counter, rgb_in, rgb_out, hsync, vsync, frame_start).
module vga_timing_gen import vga_pkg::*; #(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int RGB_W    = vga_pkg::RGB_W
) (
    input logic    clk,
    input logic    rst_n,
    vga_if.master  bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

    localparam logic [CNT_W-1:0] LINE_LEN   = to_cnt(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] FRAME_LEN  = to_cnt(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_ACT_END  = to_cnt(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = to_cnt(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = to_cnt(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = to_cnt(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = to_cnt(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = to_cnt(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic             pix_en_q;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_wrap;
    logic             unused_v_wrap;
    logic             active;
    logic             hs_zone;
    logic             vs_zone;
    logic [RGB_W-1:0] rgb_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             frame_start_q;

    // pix_en is registered from div == CLK_DIV-2 so it is high during the
    // clk in which div sits at CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div      <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            pix_en_q <= (div == DIV_PRE);
        end
    end

    vga_axis_counter u_h_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (pix_en_q),
        .total  (LINE_LEN),
        .count  (h),
        .wrap   (h_wrap)
    );

    // v steps only on the h wrap, so (last h, last v) goes straight to (0,0).
    vga_axis_counter u_v_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (h_wrap),
        .total  (FRAME_LEN),
        .count  (v),
        .wrap   (unused_v_wrap)
    );

    assign active  = (h < H_ACT_END) && (v < V_ACT_END);
    assign hs_zone = (h >= HS_FIRST) && (h <= HS_LAST);
    assign vs_zone = (v >= VS_FIRST) && (v <= VS_LAST);

    // Outputs use the counters as seen on the pix_en edge, i.e. the pixel
    // being left, so they land one clk after that pixel's pix_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en_q && (h == '0) && (v == '0);
            if (pix_en_q) begin
                rgb_q   <= active ? bus.rgb_in : '0;
                hsync_q <= !hs_zone;
                vsync_q <= !vs_zone;
            end
        end
    end

    assign bus.pix_en      = pix_en_q;
    assign bus.x_counter   = h;
    assign bus.y_counter   = v[Y_W-1:0];
    assign bus.rgb_out     = rgb_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. dut_d runs the default 640x480 timing for the
// reset, divider, line and mid-frame reset scenarios; dut_s runs a shrunken
// raster (CLK_DIV=2, 126x67) so whole frames and the renderer block fit in a
// short run. Expected pixel positions come from the clk count since reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int DD = 4;
    localparam int HD = 800;
    localparam int VD = 525;

    localparam int DS   = 2;
    localparam int HA_S = 110, HF_S = 4, HS_S = 8, HB_S = 4;
    localparam int VA_S = 60,  VF_S = 2, VS_S = 2, VB_S = 3;
    localparam int HT_S = HA_S + HF_S + HS_S + HB_S;
    localparam int VT_S = VA_S + VF_S + VS_S + VB_S;
    localparam int F_S  = HT_S * VT_S * DS;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ecnt = 0;
    int   checks = 0;
    int   failures = 0;

    vga_if bus_d ();
    vga_if bus_s ();

    vga_timing_gen dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d)
    );

    vga_timing_gen #(
        .CLK_DIV (DS),
        .H_ACTIVE(HA_S), .H_FP(HF_S), .H_SYNC(HS_S), .H_BP(HB_S),
        .V_ACTIVE(VA_S), .V_FP(VF_S), .V_SYNC(VS_S), .V_BP(VB_S),
        .RGB_W   (8)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    // Clk edges seen with rst_n high since the last reset edge.
    always @(posedge clk) ecnt <= (!rst_n) ? 0 : ecnt + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic bit pix_due(input int e, input int div);
        return (e >= div - 1) && (((e + 1) % div) == 0);
    endfunction

    function automatic bit pix_edge(input int e, input int div);
        return (e >= div) && ((e % div) == 0);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_d.rgb_in = 8'hFF;
        bus_s.rgb_in = 8'hFF;
        repeat (5) @(negedge clk);
        checks++; if (bus_d.rgb_out !== 8'h00) begin failures++; $display("FAIL reset_rgb got=%h exp=00", bus_d.rgb_out); end
        checks++; if (bus_d.hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", bus_d.hsync); end
        checks++; if (bus_d.vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", bus_d.vsync); end
        checks++; if (bus_d.pix_en !== 1'b0) begin failures++; $display("FAIL reset_pix_en got=%b exp=0", bus_d.pix_en); end
        checks++; if (bus_d.x_counter !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", bus_d.x_counter); end
        checks++; if (bus_d.y_counter !== 9'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", bus_d.y_counter); end
        checks++; if (bus_d.frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", bus_d.frame_start); end
        checks++; if (bus_s.rgb_out !== 8'h00) begin failures++; $display("FAIL reset_rgb_s got=%h exp=00", bus_s.rgb_out); end
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            checks++; if (bus_d.pix_en !== pix_due(e, DD)) begin failures++; $display("FAIL first_pix_en e=%0d got=%b exp=%b", e, bus_d.pix_en, pix_due(e, DD)); end
            checks++; if (bus_s.pix_en !== pix_due(e, DS)) begin failures++; $display("FAIL first_pix_en_s e=%0d got=%b exp=%b", e, bus_s.pix_en, pix_due(e, DS)); end
        end
        checks++; if (bus_d.frame_start !== 1'b1) begin failures++; $display("FAIL first_fs got=%b exp=1", bus_d.frame_start); end
        checks++; if (bus_d.x_counter !== 10'd1) begin failures++; $display("FAIL first_x got=%0d exp=1", bus_d.x_counter); end
        checks++; if (bus_d.rgb_out !== 8'hFF) begin failures++; $display("FAIL first_rgb got=%h exp=ff", bus_d.rgb_out); end
    endtask

    task automatic test_divider();
        int e;
        int highs;
        highs = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = ecnt;
            checks++; if (bus_d.pix_en !== pix_due(e, DD)) begin failures++; $display("FAIL div_pix_en e=%0d got=%b exp=%b", e, bus_d.pix_en, pix_due(e, DD)); end
            checks++; if (bus_d.x_counter !== 10'((e / DD) % HD)) begin failures++; $display("FAIL div_x e=%0d got=%0d exp=%0d", e, bus_d.x_counter, (e / DD) % HD); end
            if (bus_d.pix_en === 1'b1) highs++;
        end
        checks++; if (highs != 10) begin failures++; $display("FAIL div_count got=%0d exp=10", highs); end
    endtask

    task automatic test_hsync_blank();
        exp_t q[$];
        exp_t ex;
        int e, k, lows, first_low;
        lows = 0;
        first_low = -1;
        do_reset();
        bus_d.rgb_in = 8'hFF;
        for (int i = 0; i < (HD + 2) * DD; i++) begin
            @(negedge clk);
            e = ecnt;
            if (pix_edge(e, DD)) begin
                if (q.size() == 0) begin
                    checks++; failures++; $display("FAIL hsync_sb_empty e=%0d got=none exp=entry", e);
                end else begin
                    ex = q.pop_front();
                    checks++; if (bus_d.rgb_out !== ex.rgb) begin failures++; $display("FAIL blank_rgb h=%0d got=%h exp=%h", ex.h, bus_d.rgb_out, ex.rgb); end
                    checks++; if (bus_d.hsync !== ex.hs) begin failures++; $display("FAIL hsync h=%0d got=%b exp=%b", ex.h, bus_d.hsync, ex.hs); end
                    if (ex.v == 0 && bus_d.hsync === 1'b0) begin
                        lows++;
                        if (first_low < 0) first_low = ex.h;
                    end
                end
            end
            if (pix_due(e, DD)) begin
                k = (e + 1) / DD - 1;
                ex.h = k % HD;
                ex.v = (k / HD) % VD;
                ex.rgb = (ex.h < 640 && ex.v < 480) ? 8'hFF : 8'h00;
                ex.hs = !(ex.h >= 656 && ex.h <= 751);
                ex.vs = !(ex.v >= 490 && ex.v <= 491);
                q.push_back(ex);
            end
        end
        checks++; if (lows != 96) begin failures++; $display("FAIL hsync_width got=%0d exp=96", lows); end
        checks++; if (first_low != 656) begin failures++; $display("FAIL hsync_start got=%0d exp=656", first_low); end
    endtask

    task automatic test_frame_wrap();
        exp_t q[$];
        exp_t ex;
        int e, n, k, vlows, nfs, last_fs;
        logic exp_fs;
        vlows = 0;
        nfs = 0;
        last_fs = -1;
        do_reset();
        bus_s.rgb_in = 8'h00;
        for (int i = 0; i < 2 * F_S + 4; i++) begin
            @(negedge clk);
            e = ecnt;
            n = e / DS;
            checks++; if (bus_s.x_counter !== 10'(n % HT_S)) begin failures++; $display("FAIL frame_x e=%0d got=%0d exp=%0d", e, bus_s.x_counter, n % HT_S); end
            checks++; if (bus_s.y_counter !== 9'((n / HT_S) % VT_S)) begin failures++; $display("FAIL frame_y e=%0d got=%0d exp=%0d", e, bus_s.y_counter, (n / HT_S) % VT_S); end
            exp_fs = pix_edge(e, DS) && (((e / DS - 1) % (HT_S * VT_S)) == 0);
            checks++; if (bus_s.frame_start !== exp_fs) begin failures++; $display("FAIL frame_start e=%0d got=%b exp=%b", e, bus_s.frame_start, exp_fs); end
            if (bus_s.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++; if (e - last_fs != F_S) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", e - last_fs, F_S); end
                end
                nfs++;
                last_fs = e;
            end
            if (pix_edge(e, DS)) begin
                if (q.size() == 0) begin
                    checks++; failures++; $display("FAIL vsync_sb_empty e=%0d got=none exp=entry", e);
                end else begin
                    ex = q.pop_front();
                    checks++; if (bus_s.vsync !== ex.vs) begin failures++; $display("FAIL vsync h=%0d v=%0d got=%b exp=%b", ex.h, ex.v, bus_s.vsync, ex.vs); end
                    if ((e / DS - 1) < HT_S * VT_S && bus_s.vsync === 1'b0) vlows++;
                end
            end
            if (pix_due(e, DS)) begin
                k = (e + 1) / DS - 1;
                ex.h = k % HT_S;
                ex.v = (k / HT_S) % VT_S;
                ex.rgb = 8'h00;
                ex.hs = !(ex.h >= HA_S + HF_S && ex.h <= HA_S + HF_S + HS_S - 1);
                ex.vs = !(ex.v >= VA_S + VF_S && ex.v <= VA_S + VF_S + VS_S - 1);
                q.push_back(ex);
            end
        end
        checks++; if (nfs != 3) begin failures++; $display("FAIL frame_start_count got=%0d exp=3", nfs); end
        checks++; if (vlows != VS_S * HT_S) begin failures++; $display("FAIL vsync_width got=%0d exp=%0d", vlows, VS_S * HT_S); end
    endtask

    task automatic test_renderer();
        exp_t q[$];
        exp_t ex;
        int e, k, lit;
        logic [9:0] px;
        logic [8:0] py;
        lit = 0;
        px = 10'd0;
        py = 9'd0;
        do_reset();
        bus_s.rgb_in = 8'h00;
        for (int i = 0; i < F_S + 4; i++) begin
            @(negedge clk);
            e = ecnt;
            // 1-clk registered renderer: colour reflects the counters of the previous clk.
            bus_s.rgb_in = (px >= 10'd100 && px <= 10'd107 && py >= 9'd50 && py <= 9'd57) ? 8'hE0 : 8'h00;
            px = bus_s.x_counter;
            py = bus_s.y_counter;
            if (pix_edge(e, DS)) begin
                if (q.size() == 0) begin
                    checks++; failures++; $display("FAIL render_sb_empty e=%0d got=none exp=entry", e);
                end else begin
                    ex = q.pop_front();
                    checks++; if (bus_s.rgb_out !== ex.rgb) begin failures++; $display("FAIL render_rgb x=%0d y=%0d got=%h exp=%h", ex.h, ex.v, bus_s.rgb_out, ex.rgb); end
                    if (bus_s.rgb_out !== 8'h00) lit++;
                end
            end
            if (pix_due(e, DS)) begin
                k = (e + 1) / DS - 1;
                ex.h = k % HT_S;
                ex.v = (k / HT_S) % VT_S;
                ex.rgb = (ex.h >= 100 && ex.h <= 107 && ex.v >= 50 && ex.v <= 57) ? 8'hE0 : 8'h00;
                ex.hs = 1'b1;
                ex.vs = 1'b1;
                q.push_back(ex);
            end
        end
        checks++; if (lit != 64) begin failures++; $display("FAIL render_pixels got=%0d exp=64", lit); end
    endtask

    task automatic test_mid_reset();
        int target;
        target = (HD + 300) * DD;
        do_reset();
        bus_d.rgb_in = 8'hFF;
        bus_s.rgb_in = 8'hFF;
        for (int i = 0; i < target + 10 && ecnt < target; i++) @(negedge clk);
        checks++; if (bus_d.x_counter !== 10'd300) begin failures++; $display("FAIL mid_x got=%0d exp=300", bus_d.x_counter); end
        checks++; if (bus_d.y_counter !== 9'd1) begin failures++; $display("FAIL mid_y got=%0d exp=1", bus_d.y_counter); end
        checks++; if (bus_d.rgb_out !== 8'hFF) begin failures++; $display("FAIL mid_rgb got=%h exp=ff", bus_d.rgb_out); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus_d.x_counter !== 10'd0) begin failures++; $display("FAIL mrst_x got=%0d exp=0", bus_d.x_counter); end
        checks++; if (bus_d.y_counter !== 9'd0) begin failures++; $display("FAIL mrst_y got=%0d exp=0", bus_d.y_counter); end
        checks++; if (bus_d.rgb_out !== 8'h00) begin failures++; $display("FAIL mrst_rgb got=%h exp=00", bus_d.rgb_out); end
        checks++; if (bus_d.hsync !== 1'b1) begin failures++; $display("FAIL mrst_hsync got=%b exp=1", bus_d.hsync); end
        checks++; if (bus_d.vsync !== 1'b1) begin failures++; $display("FAIL mrst_vsync got=%b exp=1", bus_d.vsync); end
        checks++; if (bus_d.pix_en !== 1'b0) begin failures++; $display("FAIL mrst_pix_en got=%b exp=0", bus_d.pix_en); end
        checks++; if (bus_s.x_counter !== 10'd0) begin failures++; $display("FAIL mrst_x_s got=%0d exp=0", bus_s.x_counter); end
        checks++; if (bus_s.rgb_out !== 8'h00) begin failures++; $display("FAIL mrst_rgb_s got=%h exp=00", bus_s.rgb_out); end
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            checks++; if (bus_d.pix_en !== pix_due(e, DD)) begin failures++; $display("FAIL mrst_pix_en e=%0d got=%b exp=%b", e, bus_d.pix_en, pix_due(e, DD)); end
            if (e == 2) begin
                checks++; if (bus_s.frame_start !== 1'b1) begin failures++; $display("FAIL mrst_fs_s got=%b exp=1", bus_s.frame_start); end
            end
        end
        checks++; if (bus_d.frame_start !== 1'b1) begin failures++; $display("FAIL mrst_fs got=%b exp=1", bus_d.frame_start); end
        checks++; if (bus_d.x_counter !== 10'd1) begin failures++; $display("FAIL mrst_x_after got=%0d exp=1", bus_d.x_counter); end
    endtask

    initial begin
        bus_d.rgb_in = 8'h00;
        bus_s.rgb_in = 8'h00;
        test_reset();
        test_divider();
        test_hsync_blank();
        test_frame_wrap();
        test_renderer();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
